// File: rtl/fpu_pkg.sv
// fpu_pkg: float field widths, rounding modes and converter pipeline stage types
package fpu_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int MANT_W = FRAC_W + 1;
    localparam int SH_W   = 7;
    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RDN = 2'd2;
    localparam logic [1:0] RM_RUP = 2'd3;

    typedef struct packed {
        logic       sign;
        logic       is_nan;
        logic       is_inf;
        logic       big;
        logic       denorm;
        logic [1:0] rm;
        logic       uns;
    } flags_t;

    typedef struct packed {
        flags_t            f;
        logic [MANT_W-1:0] mant;
        logic [SH_W-1:0]   sh;
    } s1_t;
endpackage

// File: rtl/fp_round_sat.sv
// fp_round_sat: rounds an aligned magnitude, applies sign and saturates to the integer range
module fp_round_sat
    import fpu_pkg::*;
#(
    parameter int INT_W = 32
) (
    input  logic [INT_W-1:0] mag,
    input  logic             guard,
    input  logic             sticky,
    input  logic             sign,
    input  logic [1:0]       rm,
    input  logic             is_unsigned,
    input  logic             is_nan,
    input  logic             is_inf,
    input  logic             big,
    output logic [INT_W-1:0] res,
    output logic             p_lost,
    output logic             invalid
);
    localparam int RW = INT_W + 1;
    localparam logic [INT_W:0] SMAX = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic [INT_W:0] SNEG = {2'b01, {(INT_W-1){1'b0}}};

    logic           inx, inc, nz, ovf;
    logic [INT_W:0] rmag;

    // round the magnitude, then decide overflow against the signed or unsigned range
    always_comb begin
        inx  = guard | sticky;
        inc  = rm == RM_RNE ? guard & (sticky | mag[0]) :
               rm == RM_RTZ ? 1'b0 :
               rm == RM_RDN ? sign & inx : ~sign & inx;
        rmag = {1'b0, mag} + RW'(inc);
        nz   = |rmag;
        if (is_unsigned) begin
            ovf = is_nan | is_inf | big | (sign ? nz : rmag[INT_W]);
            res = (ovf & (is_nan | ~sign)) ? '1 : (sign ? '0 : rmag[INT_W-1:0]);
        end else begin
            ovf = is_nan | is_inf | big | (rmag > (sign ? SNEG : SMAX));
            res = ovf ? {1'b1, {(INT_W-1){1'b0}}} : (sign ? -rmag[INT_W-1:0] : rmag[INT_W-1:0]);
        end
        invalid = ovf;
        p_lost  = inx & ~ovf;
    end
endmodule

// File: rtl/fp_to_int_pipe.sv
// fp_to_int_pipe: 3-stage single-float to integer converter with valid/ready, tag and flush
module fp_to_int_pipe
    import fpu_pkg::*;
#(
    parameter int INT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [1:0]       rm,
    input  logic             is_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] d,
    output logic             p_lost,
    output logic             denorm,
    output logic             invalid,
    output logic [TAG_W-1:0] out_tag
);
    localparam int XW = MANT_W + INT_W + 2;
    localparam logic [9:0] SH_TOP = 10'(INT_W + BIAS - 1);
    localparam logic [9:0] SH_MAX = 10'(INT_W + 2);

    s1_t              s1_d, s1_q;
    flags_t           s2_f_d, s2_f_q;
    logic             s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q, out_valid_d, out_valid_q;
    logic [TAG_W-1:0] s1_tag_d, s1_tag_q, s2_tag_d, s2_tag_q, out_tag_d, out_tag_q;
    logic [INT_W-1:0] s2_mag_d, s2_mag_q, d_d, d_q, r_res;
    logic             s2_g_d, s2_g_q, s2_st_d, s2_st_q;
    logic             p_lost_d, p_lost_q, denorm_d, denorm_q, invalid_d, invalid_q;
    logic             s1_adv, s2_adv, s2_free, accept, r_p, r_inv;
    logic [9:0]       sh_raw;
    logic [XW-1:0]    aligned;

    // handshake: each stage moves when its successor is empty or moving; flush kills all valids
    always_comb begin
        s2_adv      = s2_valid_q & (~out_valid_q | out_ready);
        s2_free     = ~s2_valid_q | s2_adv;
        s1_adv      = s1_valid_q & s2_free;
        in_ready    = ~s1_valid_q | s1_adv;
        accept      = in_valid & in_ready & ~flush;
        s1_valid_d  = ~flush & (in_ready ? in_valid : s1_valid_q);
        s2_valid_d  = ~flush & (s2_free ? s1_valid_q : s2_valid_q);
        out_valid_d = ~flush & ((~out_valid_q | out_ready) ? s2_valid_q : out_valid_q);
    end

    // S1 decode: classify the operand and compute the saturated right-shift amount
    always_comb begin
        sh_raw   = SH_TOP - 10'(a[FRAC_W +: EXP_W]);
        s1_d     = s1_q;
        s1_tag_d = s1_tag_q;
        if (accept) begin
            s1_d.f.sign   = a[31];
            s1_d.f.is_nan = (&a[FRAC_W +: EXP_W]) & (|a[FRAC_W-1:0]);
            s1_d.f.is_inf = (&a[FRAC_W +: EXP_W]) & ~(|a[FRAC_W-1:0]);
            s1_d.f.big    = 10'(a[FRAC_W +: EXP_W]) > SH_TOP;
            s1_d.f.denorm = ~(|a[FRAC_W +: EXP_W]) & (|a[FRAC_W-1:0]);
            s1_d.f.rm     = rm;
            s1_d.f.uns    = is_unsigned;
            s1_d.mant     = {|a[FRAC_W +: EXP_W], a[FRAC_W-1:0]};
            s1_d.sh       = s1_d.f.big ? '0 : (sh_raw > SH_MAX ? SH_W'(SH_MAX) : SH_W'(sh_raw));
            s1_tag_d      = in_tag;
        end
    end

    // S2 align: the padding below the mantissa keeps every shifted-out bit inside the sticky field
    always_comb begin
        aligned  = {s1_q.mant, {(INT_W+2){1'b0}}} >> s1_q.sh;
        s2_f_d   = s2_f_q;
        s2_mag_d = s2_mag_q;
        s2_g_d   = s2_g_q;
        s2_st_d  = s2_st_q;
        s2_tag_d = s2_tag_q;
        if (s1_adv) begin
            s2_f_d   = s1_q.f;
            s2_mag_d = aligned[XW-1 -: INT_W];
            s2_g_d   = aligned[MANT_W+1];
            s2_st_d  = |aligned[MANT_W:0];
            s2_tag_d = s1_tag_q;
        end
    end

    fp_round_sat #(.INT_W(INT_W)) u_round (
        .mag        (s2_mag_q),
        .guard      (s2_g_q),
        .sticky     (s2_st_q),
        .sign       (s2_f_q.sign),
        .rm         (s2_f_q.rm),
        .is_unsigned(s2_f_q.uns),
        .is_nan     (s2_f_q.is_nan),
        .is_inf     (s2_f_q.is_inf),
        .big        (s2_f_q.big),
        .res        (r_res),
        .p_lost     (r_p),
        .invalid    (r_inv)
    );

    // S3 output register: only loads on advance so results hold while the consumer stalls
    always_comb begin
        d_d       = d_q;
        p_lost_d  = p_lost_q;
        denorm_d  = denorm_q;
        invalid_d = invalid_q;
        out_tag_d = out_tag_q;
        if (s2_adv) begin
            d_d       = r_res;
            p_lost_d  = r_p;
            denorm_d  = s2_f_q.denorm;
            invalid_d = r_inv;
            out_tag_d = s2_tag_q;
        end
    end

    // pipeline state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s1_tag_q    <= '0;
            s2_f_q      <= '0;
            s2_mag_q    <= '0;
            s2_g_q      <= 1'b0;
            s2_st_q     <= 1'b0;
            s2_tag_q    <= '0;
            d_q         <= '0;
            p_lost_q    <= 1'b0;
            denorm_q    <= 1'b0;
            invalid_q   <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s1_tag_q    <= s1_tag_d;
            s2_f_q      <= s2_f_d;
            s2_mag_q    <= s2_mag_d;
            s2_g_q      <= s2_g_d;
            s2_st_q     <= s2_st_d;
            s2_tag_q    <= s2_tag_d;
            d_q         <= d_d;
            p_lost_q    <= p_lost_d;
            denorm_q    <= denorm_d;
            invalid_q   <= invalid_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign p_lost    = p_lost_q;
    assign denorm    = denorm_q;
    assign invalid   = invalid_q;
    assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_fp_to_int_pipe.sv
// tb_fp_to_int_pipe: random and directed conversions checked against a value-level rounding model
module tb_fp_to_int_pipe;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, is_unsigned, out_valid, out_ready;
    logic        p_lost, denorm, invalid;
    logic [31:0] a, d;
    logic [1:0]  rm;
    logic [4:0]  in_tag, out_tag;
    logic        in_valid64, in_ready64, uns64, out_valid64, p_lost64, denorm64, invalid64;
    logic [31:0] a64;
    logic [63:0] d64;
    logic [1:0]  rm64;
    logic [4:0]  in_tag64, out_tag64;

    typedef struct packed {
        logic [63:0] d;
        logic        p;
        logic        dn;
        logic        inv;
    } res_t;
    typedef struct packed {
        res_t       r;
        logic [4:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0, tag_n = 0, rdy_mode = 0, rcnt = 0;

    fp_to_int_pipe #(.INT_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .rm(rm), .is_unsigned(is_unsigned), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .d(d), .p_lost(p_lost), .denorm(denorm), .invalid(invalid),
        .out_tag(out_tag)
    );

    fp_to_int_pipe #(.INT_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .rm(rm64), .is_unsigned(uns64), .in_tag(in_tag64), .out_valid(out_valid64),
        .out_ready(1'b1), .d(d64), .p_lost(p_lost64), .denorm(denorm64), .invalid(invalid64),
        .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    // exact value of the float against the rounding rules, with 128-bit integers
    function automatic res_t model(input logic [31:0] x, input logic [1:0] m, input logic u, input int w);
        logic [127:0] mant, q, r, half;
        logic         neg, exact, up, bad;
        int           e2, n;
        res_t         o;
        o    = '0;
        neg  = x[31];
        o.dn = (x[30:23] == 8'd0) && (x[22:0] != 23'd0);
        if (x[30:23] == 8'hFF) begin
            o.inv = 1'b1;
            o.d   = u ? ((neg && x[22:0] == 23'd0) ? 64'd0 : ~64'd0) : (64'd1 << (w - 1));
        end else begin
            mant = {104'd0, x[30:23] != 8'd0, x[22:0]};
            e2   = (x[30:23] == 8'd0 ? 1 : int'(x[30:23])) - 150;
            if (e2 >= 0) begin
                q    = mant << e2;
                r    = '0;
                half = 128'd1;
            end else begin
                n    = -e2;
                q    = mant >> n;
                r    = mant - (q << n);
                half = n > 100 ? '1 : (128'd1 << (n - 1));
            end
            exact = (r == 0);
            case (m)
                2'd0:    up = (r > half) || (r == half && q[0]);
                2'd1:    up = 1'b0;
                2'd2:    up = neg && !exact;
                default: up = !neg && !exact;
            endcase
            q = q + 128'(up);
            if (u) bad = neg ? (q != 0) : (q > ((128'd1 << w) - 1));
            else   bad = q > ((128'd1 << (w - 1)) - (neg ? 128'd0 : 128'd1));
            if (bad) begin
                o.inv = 1'b1;
                o.d   = u ? (neg ? 64'd0 : ~64'd0) : (64'd1 << (w - 1));
            end else begin
                o.d = neg ? -q[63:0] : q[63:0];
                o.p = !exact;
            end
        end
        if (w == 32) o.d[63:32] = 32'd0;
        return o;
    endfunction

    // out_ready pattern: always ready, 1-0-0 repeating, or random
    always @(posedge clk) begin
        #1;
        rcnt      = rdy_mode == 1 ? rcnt + 1 : 0;
        out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (rcnt % 3 == 1) : ($urandom_range(0, 2) != 0);
    end

    // scoreboard: compare the head expectation every cycle a result is presented
    always @(negedge clk) begin
        if (!rst_n) sb.delete();
        else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_result got tag=%h d=%h exp=none", out_tag, d);
                end else begin
                    chk("result", 128'({32'd0, d, p_lost, denorm, invalid, out_tag}), 128'(sb[0]));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back({model(a, rm, is_unsigned, 32), in_tag});
        end
    end

    task automatic send(input logic [31:0] x, input logic [1:0] m, input logic u);
        bit acc = 1'b0;
        in_valid = 1'b1; a = x; rm = m; is_unsigned = u; in_tag = 5'(tag_n);
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready && !flush && rst_n;
            @(posedge clk); #1;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL accept_timeout got=no_accept exp=accept");
        end
        tag_n++;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && (sb.size() != 0 || out_valid); t++) @(negedge clk);
        chk("drain_left", 128'(sb.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic run64(input logic [31:0] x, input logic [1:0] m, input logic u);
        res_t r;
        bit   seen = 1'b0;
        r = model(x, m, u, 64);
        in_valid64 = 1'b1; a64 = x; rm64 = m; uns64 = u; in_tag64 = 5'(tag_n);
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid64;
        end
        if (seen) chk("result64", 128'({d64, p_lost64, denorm64, invalid64, out_tag64}), 128'({r, 5'(tag_n)}));
        else begin
            n_chk++;
            $display("FAIL out64_timeout got=no_valid exp=valid");
        end
        tag_n++;
    endtask

    task automatic pin(input logic [31:0] x, input logic [1:0] m, input logic u, input int w,
                       input logic [63:0] ed, input logic ep, input logic edn, input logic einv);
        chk("model_pin", 128'(model(x, m, u, w)), 128'({ed, ep, edn, einv}));
        if (w == 32) send(x, m, u);
        else run64(x, m, u);
    endtask

    function automatic logic [31:0] rand_a();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(120, 160));
            default: e = 8'($urandom);
        endcase
        f = $urandom_range(0, 1) ? 23'($urandom) : (23'($urandom) & 23'h7F0000);
        return {1'($urandom), e, f};
    endfunction

    initial begin
        int k;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a = '0; rm = '0; is_unsigned = 1'b0; in_tag = '0;
        in_valid64 = 1'b0; a64 = '0; rm64 = '0; uns64 = 1'b0; in_tag64 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset32", 128'({out_valid, d, p_lost, denorm, invalid, out_tag}), 128'd0);
        chk("reset64", 128'({out_valid64, d64, p_lost64, denorm64, invalid64, out_tag64}), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h3FC00000, 2'd0, 1'b0);
        in_valid = 1'b0;
        k = 0;
        for (int t = 0; t < 20 && !out_valid; t++) begin @(negedge clk); k++; end
        chk("latency", 128'(k), 128'd3);
        @(posedge clk); #1;
        drain();

        pin(32'h3FC00000, 2'd0, 1'b0, 32, 64'h2, 1'b1, 1'b0, 1'b0);
        pin(32'h3FC00000, 2'd1, 1'b0, 32, 64'h1, 1'b1, 1'b0, 1'b0);
        pin(32'h3FC00000, 2'd2, 1'b0, 32, 64'h1, 1'b1, 1'b0, 1'b0);
        pin(32'h3FC00000, 2'd3, 1'b0, 32, 64'h2, 1'b1, 1'b0, 1'b0);
        pin(32'hBFC00000, 2'd0, 1'b0, 32, 64'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        pin(32'hBFC00000, 2'd1, 1'b0, 32, 64'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        pin(32'hBFC00000, 2'd2, 1'b0, 32, 64'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        pin(32'hCF000000, 2'd0, 1'b0, 32, 64'h80000000, 1'b0, 1'b0, 1'b0);
        pin(32'h4F000000, 2'd0, 1'b0, 32, 64'h80000000, 1'b0, 1'b0, 1'b1);
        pin(32'h4F000000, 2'd0, 1'b1, 32, 64'h80000000, 1'b0, 1'b0, 1'b0);
        pin(32'h7FC00000, 2'd0, 1'b1, 32, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        pin(32'hBF000000, 2'd1, 1'b1, 32, 64'h0, 1'b1, 1'b0, 1'b0);
        pin(32'h00000001, 2'd3, 1'b0, 32, 64'h1, 1'b1, 1'b1, 1'b0);
        pin(32'h80000001, 2'd2, 1'b0, 32, 64'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        pin(32'hFF800000, 2'd0, 1'b1, 32, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(0);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send(rand_a(), 2'($urandom), 1'($urandom));
        idle(0);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send(rand_a(), 2'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(0);
        drain();

        rdy_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(rand_a(), 2'($urandom), 1'($urandom));
        a = 32'h40200000; rm = 2'd0; is_unsigned = 1'b0; in_tag = 5'(tag_n);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        chk("flush_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        tag_n++;
        idle(0);
        drain();

        for (int i = 0; i < 3; i++) send(rand_a(), 2'($urandom), 1'($urandom));
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_flight", 128'({out_valid, d, p_lost, denorm, invalid, out_tag}), 128'd0);
        @(posedge clk); #1;
        send(32'hC0200000, 2'd0, 1'b0);
        idle(0);
        drain();

        pin(32'h5F000000, 2'd0, 1'b0, 64, 64'h8000000000000000, 1'b0, 1'b0, 1'b1);
        pin(32'hDF000000, 2'd0, 1'b0, 64, 64'h8000000000000000, 1'b0, 1'b0, 1'b0);
        pin(32'h5F000000, 2'd0, 1'b1, 64, 64'h8000000000000000, 1'b0, 1'b0, 1'b0);
        pin(32'hBFC00000, 2'd0, 1'b0, 64, 64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) run64(rand_a(), 2'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
